// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch command driver.
// {s,r} command encodings and a constant-foldable max helper for counter sizing.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_t;

  // Encoded as {s,r}
  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_CLR     = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [1:0] sr_cmd(input logic level);
    return level ? SR_SET : SR_CLR;
  endfunction

endpackage

// File: rtl/sr_fb_sync.sv
// Multi-flop synchronizer for the asynchronous latch Q readback.
// The chain clears to 0 under reset.
module sr_fb_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/sr_latch_driver.sv
// Command-side driver for a level-sensitive SR latch: timed s/r/en pulse,
// quiet gap, then synchronized Q readback reporting done or err.
//
// state | meaning
// IDLE  | outputs quiet, req_ready high, waiting for a request
// DRIVE | en=1 with s or r for PULSE_W cycles
// GAP   | s=r=en=0 for GAP_W cycles so the latch settles
// CHECK | compare q_sync with level for up to CHK_TIMEOUT cycles
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W     = 4,
  parameter int GAP_W       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CHK_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic s,
  output logic r,
  output logic en,
  input  logic q_fb,
  output logic busy,
  output logic done,
  output logic err,
  output logic err_sticky,
  input  logic err_clr
);

  localparam int CNT_MAX = max3(PULSE_W, GAP_W, CHK_TIMEOUT);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W - 1);
  localparam logic [CW-1:0] CHK_LD   = CW'(CHK_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          level;
  logic          q_sync;

  sr_fb_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (q_fb),
    .q     (q_sync)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      level      <= 1'b0;
      s          <= 1'b0;
      r          <= 1'b0;
      en         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      req_ready  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // A timeout in CHECK below overrides this clear in the same cycle
      if (err_clr) begin
        err_sticky <= 1'b0;
      end

      case (state)
        IDLE: begin
          {s, r} <= SR_HOLD;
          en     <= 1'b0;
          if (req_valid && req_ready) begin
            level     <= req_level;
            state     <= DRIVE;
            cnt       <= PULSE_LD;
            {s, r}    <= sr_cmd(req_level);
            en        <= 1'b1;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end else begin
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        DRIVE: begin
          if (cnt == '0) begin
            state  <= GAP;
            cnt    <= GAP_LD;
            {s, r} <= SR_HOLD;
            en     <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        GAP: begin
          if (cnt == '0) begin
            state <= CHECK;
            cnt   <= CHK_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        CHECK: begin
          if (q_sync == level) begin
            done      <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else if (cnt == '0) begin
            err        <= 1'b1;
            err_sticky <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          {s, r}    <= SR_HOLD;
          en        <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

  a_no_illegal : assert property (@(posedge clk) {s, r} != SR_ILLEGAL);
  a_quiet_off  : assert property (@(posedge clk) !en |-> ({s, r} == SR_HOLD));
  a_done_err   : assert property (@(posedge clk) !(done && err));

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver with a delayed SR latch model and
// a scoreboard of expected done/err outcomes and latencies.
module tb_sr_latch_driver;

  localparam int PULSE_W     = 4;
  localparam int GAP_W       = 2;
  localparam int CHK_TIMEOUT = 8;
  localparam int LAT_DONE    = PULSE_W + GAP_W + 1;
  localparam int LAT_ERR     = PULSE_W + GAP_W + CHK_TIMEOUT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_level = 1'b0;
  logic req_ready, s, r, en, busy, done, err, err_sticky;
  logic q_fb;
  logic err_clr = 1'b0;

  // Latch model: Q appears on q_fb two cycles after the latch captures it
  logic lq = 1'b0, qd1 = 1'b0, qd2 = 1'b0;
  logic stuck_en = 1'b0, stuck_val = 1'b0;
  assign q_fb = stuck_en ? stuck_val : qd2;

  typedef struct {bit is_err; int acc;} exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_count = 0;
  int done_count = 0;

  sr_latch_driver #(
    .PULSE_W(PULSE_W), .GAP_W(GAP_W), .SYNC_STAGES(2), .CHK_TIMEOUT(CHK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_level(req_level),
    .req_ready(req_ready), .s(s), .r(r), .en(en), .q_fb(q_fb), .busy(busy),
    .done(done), .err(err), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en && s) lq <= 1'b1;
    else if (en && r) lq <= 1'b0;
    qd1 <= lq;
    qd2 <= qd1;
  end

  // Accept monitor: push the expected outcome at every accepting edge
  always @(posedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      sb.push_back('{is_err: (stuck_en && (stuck_val != req_level)), acc: cyc + 1});
      acc_count++;
    end
    cyc++;
  end

  // Result monitor and invariants
  always @(negedge clk) begin
    n_tests++;
    if ((s && r) || (!en && (s || r)) || (done && err) || (req_ready && busy)) begin
      n_fail++;
      $display("FAIL invariant: s=%0b r=%0b en=%0b done=%0b err=%0b ready=%0b busy=%0b",
               s, r, en, done, err, req_ready, busy);
    end
    if (done || err) begin
      if (done) done_count++;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: done=%0b err=%0b with no request pending", done, err);
      end else begin
        exp_t e;
        int lat;
        e = sb.pop_front();
        lat = cyc - e.acc;
        if (err !== e.is_err || lat != (e.is_err ? LAT_ERR : LAT_DONE)) begin
          n_fail++;
          $display("FAIL result: err=%0b latency=%0d required err=%0b latency=%0d",
                   err, lat, e.is_err, e.is_err ? LAT_ERR : LAT_DONE);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({s, r, en, busy, done, err, err_sticky, req_ready} !== 8'b0000_0000) begin
      n_fail++;
      $display("FAIL reset_held: outs=%b required=00000000",
               {s, r, en, busy, done, err, err_sticky, req_ready});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({s, r, en, busy, done, err, err_sticky, req_ready} !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL reset_release: outs=%b required=00000001",
               {s, r, en, busy, done, err, err_sticky, req_ready});
    end
  endtask

  task automatic test_set();
    stuck_en = 1'b0;
    req_valid = 1'b1; req_level = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_level = 1'b0;
    for (int i = 0; i < PULSE_W; i++) begin
      n_tests++;
      if ({en, s, r} !== 3'b110) begin
        n_fail++;
        $display("FAIL set_drive[%0d]: en_s_r=%b required=110", i, {en, s, r});
      end
      @(negedge clk);
    end
    for (int i = 0; i < GAP_W; i++) begin
      n_tests++;
      if ({en, s, r} !== 3'b000) begin
        n_fail++;
        $display("FAIL set_gap[%0d]: en_s_r=%b required=000", i, {en, s, r});
      end
      @(negedge clk);
    end
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (sb.size() != 0 || err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL set_done: pending=%0d err_sticky=%0b required 0 and 0", sb.size(), err_sticky);
    end
  endtask

  task automatic test_clear_timeout();
    stuck_en = 1'b1; stuck_val = 1'b1;
    req_valid = 1'b1; req_level = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < PULSE_W; i++) begin
      n_tests++;
      if ({en, s, r} !== 3'b101) begin
        n_fail++;
        $display("FAIL clr_drive[%0d]: en_s_r=%b required=101", i, {en, s, r});
      end
      @(negedge clk);
    end
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (sb.size() != 0 || err_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_err: pending=%0d err_sticky=%0b required 0 and 1", sb.size(), err_sticky);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_tests++;
    if (err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr: err_sticky=%0b required=0", err_sticky);
    end
    stuck_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit lv [3];
    int acc0, done0;
    bit got;
    lv[0] = 1'b1; lv[1] = 1'b0; lv[2] = 1'b1;
    acc0 = acc_count; done0 = done_count;
    req_valid = 1'b1; req_level = lv[0];
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({en, s, r} !== {1'b1, lv[k], ~lv[k]}) begin
        n_fail++;
        $display("FAIL b2b_cmd[%0d]: en_s_r=%b required=%b", k, {en, s, r}, {1'b1, lv[k], ~lv[k]});
      end
      if (k < 2) req_level = lv[k+1];
      else req_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        got = done;
      end
      n_tests++;
      if (!got) begin
        n_fail++;
        $display("FAIL b2b_done[%0d]: done=0 required=1 within 40 cycles", k);
      end
      @(negedge clk);
    end
    n_tests++;
    if (acc_count - acc0 != 3 || done_count - done0 != 3 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: accepts=%0d dones=%0d pending=%0d required 3 3 0",
               acc_count - acc0, done_count - done0, sb.size());
    end
  endtask

  task automatic test_reset_mid_drive();
    req_valid = 1'b1; req_level = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    n_tests++;
    if ({s, r, en, busy, done, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_mid: s_r_en_busy_done_err=%b required=000000", {s, r, en, busy, done, err});
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_idle: ready=%0b pending=%0d required 1 and 0", req_ready, sb.size());
    end
    req_valid = 1'b1; req_level = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_level = 1'b1;
    req_valid = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_rerun: pending=%0d required=0", sb.size());
    end
  endtask

  task automatic test_err_clr_collision();
    bit got;
    stuck_en = 1'b1; stuck_val = 1'b0;
    err_clr = 1'b1;
    req_valid = 1'b1; req_level = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = err;
    end
    n_tests++;
    if (!got || err_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL err_collision: err_seen=%0b err_sticky=%0b required 1 and 1", got, err_sticky);
    end
    @(negedge clk);
    err_clr = 1'b0;
    n_tests++;
    if (err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL err_collision_clr: err_sticky=%0b required=0", err_sticky);
    end
    stuck_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_set();
    test_clear_timeout();
    test_back_to_back();
    test_reset_mid_drive();
    test_err_clr_collision();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
